// File: rtl/twos_comp_sched.sv
// Round-robin word scheduler for the shared bit-serial two's-complement datapath.
// Clears the datapath, streams the granted word LSB-first and reassembles the serial result.
module twos_comp_sched #(
  parameter int W       = 8,
  parameter int SER_LAT = 1
) (
  input  logic         t_clock,
  input  logic         r,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         ser_x,
  output logic         ser_r,
  input  logic         ser_y,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_id,
  input  logic         res_ready,
  output logic         busy
);

  // state | meaning
  // IDLE  | arbitrate requesters, accept one word
  // CLR   | one-cycle clear pulse to the datapath
  // SHIFT | issue W bits, capture W delayed result bits
  // DONE  | hold result until consumer takes it
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam int CW = $clog2(W + 1);

  state_t        state, state_nxt;
  logic          last_grant, grant, id_q, accept;
  logic [W-1:0]  sreg;
  logic [CW-1:0] iss_cnt, cap_cnt;
  logic          issuing, cap_v, cap_last;

  assign grant    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign issuing  = (state == SHIFT) && (iss_cnt != '0);
  assign cap_last = cap_v && (cap_cnt == CW'(1));
  assign res_id   = id_q;

  // Capture strobe trails the issue strobe by the datapath latency.
  generate
    if (SER_LAT == 0) begin : g_lat0
      assign cap_v = issuing;
    end else begin : g_latn
      logic [SER_LAT-1:0] vpipe;
      always_ff @(posedge t_clock or negedge r) begin
        if (!r)                 vpipe <= '0;
        else if (state != SHIFT) vpipe <= '0;
        else                    vpipe <= SER_LAT'({vpipe, issuing});
      end
      assign cap_v = vpipe[SER_LAT-1];
    end
  endgenerate

  always_ff @(posedge t_clock or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ser_x      = 1'b0;
    ser_r      = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = CLR;
      end
      CLR: begin
        ser_r     = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_x = issuing && sreg[0];
        if (cap_last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge t_clock or negedge r) begin
    if (!r) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      sreg       <= '0;
      iss_cnt    <= '0;
      cap_cnt    <= '0;
      res_data   <= '0;
    end else begin
      if (accept) begin
        sreg       <= grant ? req1_data : req0_data;
        id_q       <= grant;
        last_grant <= grant;
      end else if (issuing) begin
        sreg <= sreg >> 1;
      end
      if (state == CLR) begin
        iss_cnt <= CW'(W);
        cap_cnt <= CW'(W);
      end else begin
        if (issuing) iss_cnt <= iss_cnt - CW'(1);
        if (cap_v)   cap_cnt <= cap_cnt - CW'(1);
      end
      // Result enters at the MSB so bit 0 ends up at res_data[0] after W captures.
      if (cap_v) res_data <= {ser_y, res_data[W-1:1]};
    end
  end

endmodule

// File: tb/tb_twos_comp_sched.sv
// Scoreboard bench: three scheduler instances (SER_LAT 0/1/2), each with a behavioural
// serial complementer, exercised one at a time from shared randomized stimulus.
module tb_twos_comp_sched;
  localparam int W = 8;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       req0_valid, req1_valid, res_ready;
  logic [7:0] req0_data, req1_data;

  logic       rdy0_a[3], rdy1_a[3], serx_a[3], serr_a[3], sery_a[3];
  logic       rv_a[3], rid_a[3], busy_a[3];
  logic [7:0] rdata_a[3];

  logic       rdy0, rdy1, ser_x_m, ser_r_m, rv, rid, busy_m, prev_rv;
  logic [7:0] rdata;

  exp_t sb[$];
  bit   m_last[3];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdy0    = rdy0_a[sel];
  assign rdy1    = rdy1_a[sel];
  assign ser_x_m = serx_a[sel];
  assign ser_r_m = serr_a[sel];
  assign rv      = rv_a[sel];
  assign rid     = rid_a[sel];
  assign busy_m  = busy_a[sel];
  assign rdata   = rdata_a[sel];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic       seen, y0;
    logic [1:0] dly;
    // Copy bits up to and including the first 1, invert afterwards.
    assign y0 = serx_a[g] ^ seen;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seen <= 1'b0;
        dly  <= 2'b00;
      end else begin
        if (serr_a[g])      seen <= 1'b0;
        else if (serx_a[g]) seen <= 1'b1;
        dly <= {dly[0], y0};
      end
    end
    assign sery_a[g] = (g == 0) ? y0 : (g == 1) ? dly[0] : dly[1];

    twos_comp_sched #(.W(W), .SER_LAT(g)) u_dut (
      .t_clock    (clk),
      .r          (rst_n),
      .req0_valid (req0_valid && (sel == 2'(g))),
      .req0_data  (req0_data),
      .req0_ready (rdy0_a[g]),
      .req1_valid (req1_valid && (sel == 2'(g))),
      .req1_data  (req1_data),
      .req1_ready (rdy1_a[g]),
      .ser_x      (serx_a[g]),
      .ser_r      (serr_a[g]),
      .ser_y      (sery_a[g]),
      .res_valid  (rv_a[g]),
      .res_data   (rdata_a[g]),
      .res_id     (rid_a[g]),
      .res_ready  (res_ready),
      .busy       (busy_a[g])
    );
  end

  function automatic logic [7:0] tc(input logic [7:0] d);
    int v;
    v = (256 - int'(d)) % 256;
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (ser_lat=%0d): got %0h, want %0h", name, sel, act, exp);
    end
  endtask

  // Monitor: latency on result rise, data/id on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv && !prev_rv) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result (ser_lat=%0d): got data %0h id %0d, want none", sel, rdata, rid);
        end else begin
          check("latency", cyc - sb[0].cyc, W + int'(sel) + 2);
        end
      end
      if (rv && res_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", rdata, e.data);
        check("res_id", rid, e.id);
      end
    end
    prev_rv <= rv;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, rv, 0);
    check({tag, "_res_data"}, rdata, 0);
    check({tag, "_res_id"}, rid, 0);
    check({tag, "_ser_x"}, ser_x_m, 0);
    check({tag, "_ser_r"}, ser_r_m, 0);
    check({tag, "_busy"}, busy_m, 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) m_last[i] = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    check("rst_ready0", rdy0, 0);
    check("rst_ready1", rdy1, 0);
  endtask

  // Present words, predict the grant order, push expected results at each handshake.
  task automatic issue(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                       input bit churn);
    bit         p0, p1, g;
    int         budget;
    logic [7:0] d;
    p0 = v0; p1 = v1; budget = 0;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    while ((p0 || p1) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (rdy0 || rdy1) begin
        g = (p0 && p1) ? !m_last[sel] : p1;
        check("grant", {30'd0, rdy1, rdy0}, g ? 32'd2 : 32'd1);
        d = g ? req1_data : req0_data;
        sb.push_back('{id: g, data: tc(d), cyc: cyc});
        m_last[sel] = g;
        @(posedge clk); #1;
        if (g) begin req1_valid = 1'b0; p1 = 1'b0; end
        else   begin req0_valid = 1'b0; p0 = 1'b0; end
      end else begin
        @(posedge clk); #1;
      end
      if (churn) begin
        if (p0) req0_data = 8'($urandom);
        if (p1) req1_data = 8'($urandom);
      end
    end
    if (p0 || p1) begin
      n_err++;
      $display("FAIL accept_timeout (ser_lat=%0d): got no ready, want ready within 200 cycles", sel);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || busy_m) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("drain_empty", sb.size(), 0);
    check("drain_idle", busy_m, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_basic();
    do_reset();
    issue(1, 8'h05, 0, 8'h00, 0);
    drain();
    issue(1, 8'h01, 1, 8'h02, 0);
    drain();
    issue(1, 8'h03, 0, 8'h00, 0);
    drain();
    issue(1, 8'($urandom), 1, 8'($urandom), 0);
    drain();
    issue(1, 8'h00, 0, 8'h00, 0);
    issue(0, 8'h00, 1, 8'h80, 0);
    drain();
    for (int d = 1; d < 256; d++) begin
      int who;
      who = int'($urandom_range(0, 1));
      issue(who == 0, 8'(d), who == 1, 8'(d), 0);
    end
    drain();
    for (int k = 0; k < 20; k++) issue(1, 8'($urandom), 1, 8'($urandom), 1);
    drain();
  endtask

  task automatic run_hold_and_abort();
    int b;
    // Consumer stalls while DONE; requesters wait, then give up before any grant.
    res_ready = 1'b0;
    issue(1, 8'h37, 0, 8'h00, 0);
    b = 0;
    while (!rv && b < 40) begin
      @(negedge clk);
      b++;
    end
    check("hold_reached", rv, 1);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", rv, 1);
      check("hold_data", rdata, tc(8'h37));
      check("hold_id", rid, 0);
      check("hold_ready0", rdy0, 0);
      check("hold_ready1", rdy1, 0);
      check("hold_busy", busy_m, 1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    drain();
    repeat (5) @(negedge clk);
    check("no_ghost_word", busy_m, 0);
    @(posedge clk); #1;

    // Reset in the middle of a word drops it without a result.
    issue(0, 8'h00, 1, 8'h44, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy_m, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_outputs("abort");
    check("abort_ready0", rdy0, 0);
    check("abort_ready1", rdy1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) m_last[i] = 1'b1;
    @(posedge clk); #1;
    issue(0, 8'h00, 1, 8'h0C, 0);
    drain();
  endtask

  initial begin
    logic [1:0] order[3];
    order      = '{2'd1, 2'd0, 2'd2};
    rst_n      = 1'b0;
    sel        = 2'd1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    res_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = order[k];
      run_basic();
      if (sel == 2'd1) run_hold_and_abort();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
